// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for a row of common-anode 7-segment hex digits.
// A free-running divider paces the scan. Each digit is shown for 2^DIV_W
// clocks, and the first clock of every digit slot is blanked to suppress
// ghosting. Host writes land in a shadow register. They are promoted to the
// active register only at a frame boundary, so a frame is never torn.
//
// Parameters
//   DIGITS  number of multiplexed digits (1..16)
//   DIV_W   scan divider width; one digit slot = 2^DIV_W clocks (2..24)
//
// Ports
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset
//   data     4*DIGITS hex nibbles, nibble k drives digit k
//   points   per-digit decimal point, 1 = lit
//   enable   per-digit enable, 0 = digit fully dark
//   load     one-cycle strobe capturing data/points/enable into the shadow
//   pending  shadow holds values not yet committed to the display
//   seg_n    active-low segments {p,g,f,e,d,c,b,a}
//   an_n     active-low digit select, at most one bit low
//
// Optional feature (macro SEG_BLINK_EN)
//   Adds input blink[DIGITS-1:0], which is shadowed and committed with the
//   other fields. It also adds a 6-bit frame counter. Blinking digits are dark
//   while bit 5 of that counter is set.
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int DIGITS = 8,
  parameter int DIV_W  = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     enable,
`ifdef SEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink,
`endif
  input  logic                  load,
  output logic                  pending,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_font = 7'b011_1111;
      4'h1:    hex_font = 7'b000_0110;
      4'h2:    hex_font = 7'b101_1011;
      4'h3:    hex_font = 7'b100_1111;
      4'h4:    hex_font = 7'b110_0110;
      4'h5:    hex_font = 7'b110_1101;
      4'h6:    hex_font = 7'b111_1101;
      4'h7:    hex_font = 7'b000_0111;
      4'h8:    hex_font = 7'b111_1111;
      4'h9:    hex_font = 7'b110_1111;
      4'hA:    hex_font = 7'b111_0111;
      4'hB:    hex_font = 7'b111_1100;
      4'hC:    hex_font = 7'b011_1001;
      4'hD:    hex_font = 7'b101_1110;
      4'hE:    hex_font = 7'b111_1001;
      default: hex_font = 7'b111_0001;
    endcase
  endfunction

  logic [DIV_W-1:0]    div;
  logic [IDX_W-1:0]    idx;

  logic [4*DIGITS-1:0] shadow_data,   active_data;
  logic [DIGITS-1:0]   shadow_points, active_points;
  logic [DIGITS-1:0]   shadow_enable, active_enable;

  logic                tick;
  logic                wrap;
  logic                commit;
  logic                dark;
  logic [3:0]          cur_nib;
  logic [7:0]          seg_d;
  logic [DIGITS-1:0]   an_d;

  assign tick    = &div;
  assign wrap    = tick && (idx == LAST_IDX);
  assign commit  = wrap && pending;
  assign cur_nib = active_data[4*idx +: 4];

`ifdef SEG_BLINK_EN
  logic [DIGITS-1:0] shadow_blink, active_blink;
  logic [5:0]        frame_cnt;

  assign dark = !active_enable[idx] || (active_blink[idx] && frame_cnt[5]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_blink <= '0;
      active_blink <= '0;
      frame_cnt    <= '0;
    end else begin
      if (commit) active_blink <= shadow_blink;
      if (load)   shadow_blink <= blink;
      if (wrap)   frame_cnt    <= frame_cnt + 6'd1;
    end
  end
`else
  assign dark = !active_enable[idx];
`endif

  // Next output values are decoded from the current digit. On a tick cycle
  // idx is about to move, so the select lines stay blank for one clock.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    seg_d = 8'hFF;
    an_d  = '1;
    if (!dark) seg_d = ~{active_points[idx], hex_font(cur_nib)};
    if (!tick) an_d[idx] = 1'b0;
  end

  // Scan timing and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      idx   <= '0;
      seg_n <= 8'hFF;
      an_n  <= '1;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every
      // right-hand side samples the value held before this edge.
      div   <= div + DIV_W'(1);
      seg_n <= seg_d;
      an_n  <= an_d;
      if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

  // Double-buffered frame contents. Commit happens only at the frame wrap.
  // A load on that same edge refills the shadow and keeps pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are plain flops, not a RAM, so they are reset. The display
      // must come up dark and any uncommitted host data is discarded.
      shadow_data   <= '0;
      shadow_points <= '0;
      shadow_enable <= '0;
      active_data   <= '0;
      active_points <= '0;
      active_enable <= '0;
      pending       <= 1'b0;
    end else begin
      if (commit) begin
        active_data   <= shadow_data;
        active_points <= shadow_points;
        active_enable <= shadow_enable;
        pending       <= 1'b0;
      end
      if (load) begin
        shadow_data   <= data;
        shadow_points <= points;
        shadow_enable <= enable;
        pending       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Bench for seg_scan_driver. It instantiates two copies:
//   dut4: DIGITS=4, DIV_W=2, so a frame lasts 16 clocks
//   dut3: DIGITS=3, DIV_W=2, which exercises a non-power-of-two wrap
//
// A behavioural model predicts every output on every clock. The model derives
// the scan position from the number of clocks elapsed since reset, and renders
// the font from segment-letter strings. Directed sequences and a
// table-driven font sweep check literal values at the interesting points.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int DIVW = 2;
  localparam int PER  = 1 << DIVW;

  logic        clk;
  logic        rst_n;
  logic        ld, ld3;
  logic [15:0] dat;
  logic [3:0]  pts, en;
  logic [11:0] dat3;
  logic [2:0]  pts3, en3;
  logic        pend4, pend3;
  logic [7:0]  seg4, seg3;
  logic [3:0]  an4;
  logic [2:0]  an3;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.DIGITS(4), .DIV_W(DIVW)) dut4 (
    .clk(clk), .rst_n(rst_n), .data(dat), .points(pts), .enable(en),
    .load(ld), .pending(pend4), .seg_n(seg4), .an_n(an4)
  );

  seg_scan_driver #(.DIGITS(3), .DIV_W(DIVW)) dut3 (
    .clk(clk), .rst_n(rst_n), .data(dat3), .points(pts3), .enable(en3),
    .load(ld3), .pending(pend3), .seg_n(seg3), .an_n(an3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          c;        // clock edges since reset release
    int          digits;
    logic [15:0] act_d, sh_d;
    logic [3:0]  act_p, sh_p, act_e, sh_e;
    bit          pend;
  } mdl_t;

  mdl_t m4, m3;

  string font_letters [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
    "acdfg", "acdefg", "abc", "abcdefg", "abcdfg", "abcefg", "cdefg",
    "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] font_of(input logic [3:0] n);
    string s;
    logic [6:0] r;
    s = font_letters[n];
    r = '0;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  function automatic mdl_t fresh(input int digits);
    mdl_t m;
    m.c = 0; m.digits = digits;
    m.act_d = '0; m.sh_d = '0;
    m.act_p = '0; m.sh_p = '0; m.act_e = '0; m.sh_e = '0;
    m.pend = 1'b0;
    return m;
  endfunction

  // Outputs that appear after the next edge, computed from the model state
  // before that edge.
  function automatic void predict(input mdl_t m, output logic [15:0] an,
                                  output logic [7:0] seg);
    int   idx;
    bit   tick;
    logic [15:0] mask;
    idx  = (m.c / PER) % m.digits;
    tick = (m.c % PER) == PER - 1;
    mask = 16'((32'h1 << m.digits) - 1);
    an   = tick ? mask : (~(16'h1 << idx)) & mask;
    seg  = m.act_e[idx] ? ~{m.act_p[idx], font_of(m.act_d[4*idx +: 4])} : 8'hFF;
  endfunction

  function automatic mdl_t advance(input mdl_t m, input bit l,
                                   input logic [15:0] d, input logic [3:0] p,
                                   input logic [3:0] e);
    bit wrap;
    wrap = (m.c % PER == PER - 1) && ((m.c / PER) % m.digits == m.digits - 1);
    if (wrap && m.pend) begin
      m.act_d = m.sh_d; m.act_p = m.sh_p; m.act_e = m.sh_e; m.pend = 1'b0;
    end
    if (l) begin
      m.sh_d = d; m.sh_p = p; m.sh_e = e; m.pend = 1'b1;
    end
    m.c++;
    return m;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: predict, clock, then compare both DUTs on the falling edge.
  task automatic step();
    logic [15:0] ea4, ea3;
    logic [7:0]  es4, es3;
    predict(m4, ea4, es4);
    predict(m3, ea3, es3);
    m4 = advance(m4, ld, dat, pts, en);
    m3 = advance(m3, ld3, {4'h0, dat3}, {1'b0, pts3}, {1'b0, en3});
    @(posedge clk);
    @(negedge clk);
    ld  = 1'b0;
    ld3 = 1'b0;
    check("model_an4",   32'(an4),   32'(ea4));
    check("model_seg4",  32'(seg4),  32'(es4));
    check("model_pend4", 32'(pend4), 32'(m4.pend));
    check("model_an3",   32'(an3),   32'(ea3));
    check("model_seg3",  32'(seg3),  32'(es3));
    check("model_pend3", 32'(pend3), 32'(m3.pend));
  endtask

  task automatic wait_an4(input logic [3:0] target, input string name);
    int n = 0;
    while (an4 !== target && n < 64) begin step(); n++; end
    if (an4 !== target) check({name, "_timeout"}, 32'(an4), 32'(target));
  endtask

  task automatic wait_commit(input bit third, input string name);
    int n = 0;
    while ((third ? pend3 : pend4) !== 1'b0 && n < 64) begin step(); n++; end
    if ((third ? pend3 : pend4) !== 1'b0)
      check({name, "_timeout"}, 32'(third ? pend3 : pend4), 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pend4"}, 32'(pend4), 32'h0);
    check({tag, "_seg4"},  32'(seg4),  32'hFF);
    check({tag, "_an4"},   32'(an4),   32'hF);
    check({tag, "_pend3"}, 32'(pend3), 32'h0);
    check({tag, "_seg3"},  32'(seg3),  32'hFF);
    check({tag, "_an3"},   32'(an3),   32'h7);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    m4 = fresh(4);
    m3 = fresh(3);
  endtask

  // ---------------- font sweep table ----------------
  typedef struct {
    logic [3:0] nib;
    logic       pt;
    logic [7:0] exp_seg;
  } font_vec_t;

  font_vec_t fvec [18];

  logic [3:0] scan_an  [4];
  logic [7:0] scan_seg [4];
  logic [2:0] scan3_an [3];
  logic [7:0] scan3_seg[3];

  initial begin
    fvec = '{'{4'h0, 1'b0, 8'hC0}, '{4'h1, 1'b0, 8'hF9}, '{4'h2, 1'b0, 8'hA4},
             '{4'h3, 1'b0, 8'hB0}, '{4'h4, 1'b0, 8'h99}, '{4'h5, 1'b0, 8'h92},
             '{4'h6, 1'b0, 8'h82}, '{4'h7, 1'b0, 8'hF8}, '{4'h8, 1'b0, 8'h80},
             '{4'h9, 1'b0, 8'h90}, '{4'hA, 1'b0, 8'h88}, '{4'hB, 1'b0, 8'h83},
             '{4'hC, 1'b0, 8'hC6}, '{4'hD, 1'b0, 8'hA1}, '{4'hE, 1'b0, 8'h86},
             '{4'hF, 1'b0, 8'h8E}, '{4'h0, 1'b1, 8'h40}, '{4'h8, 1'b1, 8'h00}};
    scan_an   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    scan_seg  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    scan3_an  = '{3'b110, 3'b101, 3'b011};
    scan3_seg = '{8'hC0, 8'hFF, 8'hA4};

    rst_n = 1'b0;
    ld = 1'b0; ld3 = 1'b0;
    dat = '0; pts = '0; en = '0;
    dat3 = '0; pts3 = '0; en3 = '0;
    m4 = fresh(4);
    m3 = fresh(3);

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    release_reset();

    // Dark until loaded; changes to the inputs without load are ignored.
    for (int i = 0; i < 6; i++) begin
      dat = 16'($urandom); en = 4'hF; pts = 4'($urandom);
      step();
    end

    // Basic scan of 3210 with ghost blanking between digits.
    dat = 16'h3210; en = 4'hF; pts = 4'h0; ld = 1'b1;
    step();
    check("s1_pending_set", 32'(pend4), 32'h1);
    wait_commit(1'b0, "s1_commit");
    check("s1_ghost_after_commit", 32'(an4), 32'hF);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        check("s1_scan_an",  32'(an4),  32'(scan_an[k]));
        check("s1_scan_seg", 32'(seg4), 32'(scan_seg[k]));
      end
      step();
      check("s1_ghost", 32'(an4), 32'hF);
    end

    // Font sweep on digit 0, with the decimal point exercised.
    for (int v = 0; v < 18; v++) begin
      dat = {12'h0, fvec[v].nib}; pts = {3'b0, fvec[v].pt}; en = 4'h1; ld = 1'b1;
      step();
      wait_commit(1'b0, "font_commit");
      wait_an4(4'b1110, "font_digit0");
      check("font_seg", 32'(seg4), 32'(fvec[v].exp_seg));
    end

    // A load mid-frame must not tear the frame.
    dat = 16'h3210; en = 4'hF; pts = 4'h0; ld = 1'b1;
    step();
    wait_commit(1'b0, "s3_commit");
    wait_an4(4'b1011, "s3_idx2");
    dat = 16'hFFFF; ld = 1'b1;
    step();
    check("s3_old_digit2", 32'(seg4),  32'hA4);
    check("s3_pending",    32'(pend4), 32'h1);
    wait_an4(4'b0111, "s3_idx3");
    check("s3_old_digit3", 32'(seg4),  32'hB0);
    wait_an4(4'b1110, "s3_new_frame");
    check("s3_new_digit0", 32'(seg4),  32'h8E);
    check("s3_committed",  32'(pend4), 32'h0);

    // Last load before the wrap wins. A load on the commit edge stays pending.
    dat = 16'h1111; ld = 1'b1;
    step();
    step();
    dat = 16'h2222; ld = 1'b1;
    step();
    begin
      int n = 0;
      while (m4.c % 16 != 15 && n < 32) begin step(); n++; end
    end
    dat = 16'h3333; ld = 1'b1;
    step();
    check("s4_pending_kept", 32'(pend4), 32'h1);
    wait_an4(4'b1110, "s4_frame_a");
    check("s4_last_wins", 32'(seg4),  32'hA4);
    check("s4_still_pend", 32'(pend4), 32'h1);
    wait_an4(4'b1101, "s4_mid");
    wait_an4(4'b1110, "s4_frame_b");
    check("s4_coincident", 32'(seg4),  32'hB0);
    check("s4_pend_clear", 32'(pend4), 32'h0);

    // Three-digit variant: digit 1 disabled, wrap 2 -> 0.
    dat3 = 12'h210; en3 = 3'b101; pts3 = 3'b000; ld3 = 1'b1;
    step();
    wait_commit(1'b1, "s5_commit");
    check("s5_ghost", 32'(an3), 32'h7);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        check("s5_scan_an",  32'(an3),  32'(scan3_an[k]));
        check("s5_scan_seg", 32'(seg3), 32'(scan3_seg[k]));
      end
      step();
      check("s5_ghost", 32'(an3), 32'h7);
    end
    step();
    check("s5_wrap_an",  32'(an3),  32'b110);
    check("s5_wrap_seg", 32'(seg3), 32'hC0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      dat  = 16'($urandom); pts  = 4'($urandom); en  = 4'($urandom);
      dat3 = 12'($urandom); pts3 = 3'($urandom); en3 = 3'($urandom);
      ld   = ($urandom_range(0, 7) == 0);
      ld3  = ($urandom_range(0, 7) == 0);
      step();
    end

    // Asynchronous reset between edges with a load still pending.
    dat = 16'hABCD; en = 4'hF; ld = 1'b1;
    dat3 = 12'h123; en3 = 3'h7; ld3 = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    @(negedge clk);
    release_reset();
    for (int i = 0; i < 40; i++) begin
      dat = 16'($urandom); en = 4'hF;
      dat3 = 12'($urandom); en3 = 3'h7;
      step();
    end
    check("post_reset_dark4", 32'(seg4), 32'hFF);
    check("post_reset_dark3", 32'(seg3), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
